// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data memory between core (C) and loader (L) ports
// Optional grant counters (c_cnt/l_cnt/cnt_clr) are built when DMEM_ARB_CNT_EN is defined.

module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef DMEM_ARB_CNT_EN
    input  logic          cnt_clr,
    output logic [15:0]   c_cnt,
    output logic [15:0]   l_cnt,
`endif
    output logic          busy
);

    generate
        if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("dmem_arbiter: RD_LAT must be in 0..3");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CW = 2;

    state_t        state;
    logic          owner;       // 1 = loader owns the access in flight
    logic          last_owner;  // 1 = loader won the most recent grant
    logic          lat_we;
    logic [CW-1:0] wait_cnt;

    logic          pick_l;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // On a tie the port that did not win last time gets the memory.
    assign pick_l    = (c_req && l_req) ? ~last_owner : l_req;
    assign sel_we    = pick_l ? l_we    : c_we;
    assign sel_addr  = pick_l ? l_addr  : c_addr;
    assign sel_wdata = pick_l ? l_wdata : c_wdata;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            wait_cnt   <= '0;
            c_gnt      <= 1'b0;
            l_gnt      <= 1'b0;
            c_rvalid   <= 1'b0;
            l_rvalid   <= 1'b0;
            c_rdata    <= '0;
            l_rdata    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            c_gnt    <= 1'b0;
            l_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_req || l_req) begin
                        owner      <= pick_l;
                        last_owner <= pick_l;
                        lat_we     <= sel_we;
                        c_gnt      <= ~pick_l;
                        l_gnt      <= pick_l;
                        mem_addr   <= sel_addr;
                        mem_write  <= sel_we;
                        mem_read   <= ~sel_we;
                        mem_wdata  <= sel_we ? sel_wdata : '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        mem_write <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= IDLE;
                    end else if (RD_LAT == 0) begin
                        // Zero-latency memory: data is valid during the issue cycle itself.
                        mem_read <= 1'b0;
                        if (owner) begin
                            l_rdata  <= mem_rdata;
                            l_rvalid <= 1'b1;
                        end else begin
                            c_rdata  <= mem_rdata;
                            c_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= CW'(RD_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        mem_read <= 1'b0;
                        if (owner) begin
                            l_rdata  <= mem_rdata;
                            l_rvalid <= 1'b1;
                        end else begin
                            c_rdata  <= mem_rdata;
                            c_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            c_cnt <= '0;
            l_cnt <= '0;
        end else begin
            if (c_gnt && c_cnt != 16'hFFFF)
                c_cnt <= c_cnt + 16'd1;
            if (l_gnt && l_cnt != 16'hFFFF)
                l_cnt <= l_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at RD_LAT=0 (u_a) and RD_LAT=2 (u_b)

module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       c_req, c_we, l_req, l_we;
    logic [7:0] c_addr, c_wdata, l_addr, l_wdata;

    logic       c_gnt_a, c_rvalid_a, l_gnt_a, l_rvalid_a, mem_read_a, mem_write_a, busy_a;
    logic [7:0] c_rdata_a, l_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic       c_gnt_b, c_rvalid_b, l_gnt_b, l_rvalid_b, mem_read_b, mem_write_b, busy_b;
    logic [7:0] c_rdata_b, l_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
`ifdef DMEM_ARB_CNT_EN
    logic        cnt_clr;
    logic [15:0] c_cnt_a, l_cnt_a, c_cnt_b, l_cnt_b;
`endif

    logic [7:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;
    int both_set = 0;

    always #5 clk = ~clk;

    assign mem_rdata_a = mem[mem_addr_a];
    assign mem_rdata_b = mem[mem_addr_b];

    always @(posedge clk)
        if (mem_write_a) mem[mem_addr_a] <= mem_wdata_a;

    always @(negedge clk)
        if ((mem_read_a && mem_write_a) || (mem_read_b && mem_write_b)) both_set++;

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(0)) u_a (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_a), .c_rvalid(c_rvalid_a), .c_rdata(c_rdata_a),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_a), .l_rvalid(l_rvalid_a), .l_rdata(l_rdata_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
`ifdef DMEM_ARB_CNT_EN
        .cnt_clr(cnt_clr), .c_cnt(c_cnt_a), .l_cnt(l_cnt_a),
`endif
        .busy(busy_a)
    );

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(2)) u_b (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_b), .c_rvalid(c_rvalid_b), .c_rdata(c_rdata_b),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_b), .l_rvalid(l_rvalid_b), .l_rdata(l_rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
`ifdef DMEM_ARB_CNT_EN
        .cnt_clr(cnt_clr), .c_cnt(c_cnt_b), .l_cnt(l_cnt_b),
`endif
        .busy(busy_b)
    );

    typedef struct {
        bit         port_l;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " a ctl"}, {23'd0, c_gnt_a, c_rvalid_a, l_gnt_a, l_rvalid_a, mem_read_a,
                                mem_write_a, busy_a, mem_addr_a == 8'h00, mem_wdata_a == 8'h00}, 32'h3);
        check({tag, " a rdata"}, {16'd0, c_rdata_a, l_rdata_a}, 32'h0);
        check({tag, " b ctl"}, {23'd0, c_gnt_b, c_rvalid_b, l_gnt_b, l_rvalid_b, mem_read_b,
                                mem_write_b, busy_b, mem_addr_b == 8'h00, mem_wdata_b == 8'h00}, 32'h3);
        check({tag, " b rdata"}, {16'd0, c_rdata_b, l_rdata_b}, 32'h0);
    endtask

    initial begin
        vec_t v;
        int   rv_seen;
        int   gcount;
        logic [3:0] exp_ev;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
`ifdef DMEM_ARB_CNT_EN
        cnt_clr = 1'b0;
`endif

        tbl[0] = '{1'b0, 1'b1, 8'hFD, 8'h5A, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'hFD, 8'h00, 8'h5A};
        tbl[2] = '{1'b1, 1'b1, 8'h00, 8'hA5, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hA5};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5};
        tbl[7] = '{1'b1, 1'b1, 8'hFD, 8'h77, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 8'hFD, 8'h00, 8'h77};

        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Single-cycle request pulses: each port is granted on the cycle after the pulse.
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            if (v.port_l) begin
                l_req = 1; l_we = v.we; l_addr = v.addr; l_wdata = v.wdata;
            end else begin
                c_req = 1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
            end
            tick();
            c_req = 0; l_req = 0;
            check($sformatf("v%0d gnt_a", i), {c_gnt_a, l_gnt_a}, v.port_l ? 2'b01 : 2'b10);
            check($sformatf("v%0d gnt_b", i), {c_gnt_b, l_gnt_b}, v.port_l ? 2'b01 : 2'b10);
            check($sformatf("v%0d strobe", i), {mem_write_a, mem_read_a}, v.we ? 2'b10 : 2'b01);
            check($sformatf("v%0d addr", i), mem_addr_a, v.addr);
            if (v.we) check($sformatf("v%0d wdata", i), mem_wdata_a, v.wdata);
            tick();
            if (v.we) begin
                check($sformatf("v%0d wr done", i), {busy_a, mem_write_a, mem_addr_a, mem_wdata_a}, 0);
            end else begin
                check($sformatf("v%0d rvalid_a", i), {c_rvalid_a, l_rvalid_a},
                      v.port_l ? 2'b01 : 2'b10);
                check($sformatf("v%0d rdata_a", i), v.port_l ? l_rdata_a : c_rdata_a, v.exp_rdata);
                check($sformatf("v%0d strobe off", i), mem_read_a, 1'b0);
            end
            tick(); tick();
            if (!v.we) begin
                check($sformatf("v%0d rvalid_b", i), {c_rvalid_b, l_rvalid_b},
                      v.port_l ? 2'b01 : 2'b10);
                check($sformatf("v%0d rdata_b", i), v.port_l ? l_rdata_b : c_rdata_b, v.exp_rdata);
            end
            tick();
            check($sformatf("v%0d idle", i), {busy_a, busy_b}, 2'b00);
        end

        // Both ports reading continuously: RD_LAT=2 instance alternates C,L,C,L every 5 cycles.
        reset = 1'b1; tick(); reset = 1'b0;
        c_we = 0; c_addr = 8'hFD; l_we = 0; l_addr = 8'h00;
        c_req = 1; l_req = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_ev = 4'b0000;
            if (k % 5 == 1) exp_ev = ((k / 5) % 2 == 0) ? 4'b1000 : 4'b0100;
            if (k % 5 == 4) exp_ev = ((k / 5) % 2 == 0) ? 4'b0010 : 4'b0001;
            check($sformatf("rr k%0d", k), {c_gnt_b, l_gnt_b, c_rvalid_b, l_rvalid_b}, exp_ev);
            if (exp_ev == 4'b0010) check($sformatf("rr c_rdata k%0d", k), c_rdata_b, 8'h77);
            if (exp_ev == 4'b0001) check($sformatf("rr l_rdata k%0d", k), l_rdata_b, 8'hA5);
        end
        c_req = 0; l_req = 0;
        for (int k = 0; k < 6; k++) tick();

        // Reset during the RD_LAT=2 wait: the read must never return.
        c_req = 1; c_we = 0; c_addr = 8'hFD;
        tick(); c_req = 0;
        tick();
        check("abort in wait", {busy_b, mem_read_b}, 2'b11);
        reset = 1'b1;
        tick();
        check("abort strobe drop", mem_read_b, 1'b0);
        tick();
        check_idle_outputs("abort");
        reset = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (c_rvalid_a || c_rvalid_b || l_rvalid_a || l_rvalid_b) rv_seen++;
        end
        check("abort no rvalid", rv_seen, 0);

        // Loader-only burst of 300 writes.
        l_we = 1; l_addr = 8'h40; l_wdata = 8'h11; l_req = 1;
        gcount = 0;
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (l_gnt_a) gcount++;
            if (k == 600) l_req = 0;
        end
        tick(); tick();
        if (l_gnt_a) gcount++;
        check("loader gnt count", gcount, 300);
        check("loader wrote", mem[8'h40], 8'h11);
`ifdef DMEM_ARB_CNT_EN
        check("l_cnt 300", l_cnt_a, 16'd300);
        check("c_cnt 0", c_cnt_a, 16'd0);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("cnt_clr", {c_cnt_a, l_cnt_a}, 32'h0);

        force u_a.l_cnt = 16'hFFFE;
        tick();
        release u_a.l_cnt;
        l_req = 1;
        for (int k = 0; k < 6; k++) tick();
        l_req = 0;
        tick(); tick();
        check("l_cnt saturate", l_cnt_a, 16'hFFFF);
`endif

        check("never both strobes", both_set, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
